// File: rtl/receive_unit_if.sv
// Serial link lines plus captured-word handshake for receive_unit.
// master = capture block side, slave = line driver / word consumer side.
interface receive_unit_if #(
   parameter int unsigned N = 8
);
   logic         s_clk;
   logic         s_sda;
   logic         latch;
   logic [N-1:0] data;
   logic         valid;
   logic         ready;
   logic         bit_err;
   logic         drop;

   modport master (
      input  s_clk, s_sda, latch, ready,
      output data, valid, bit_err, drop
   );

   modport slave (
      output s_clk, s_sda, latch, ready,
      input  data, valid, bit_err, drop
   );
endinterface

// File: rtl/receive_unit.sv
// Serial-to-parallel frame capture with a one-word valid/ready holding register.
// Optional feature macro RECEIVE_SYNC_EN: two-flop input synchronizer instead of one sampling flop.
module receive_unit #(
   parameter int unsigned N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   receive_unit_if.master bus
);
`ifdef RECEIVE_SYNC_EN
   localparam int unsigned D = 2;
`else
   localparam int unsigned D = 1;
`endif
   localparam int unsigned CW = $clog2(N + 2);

   typedef enum logic {IDLE, SHIFT} state_t;

   logic [D-1:0]  clk_sync, sda_sync, lat_sync;
   logic          clk_dly, lat_dly;
   logic          clk_rise, lat_fall, sda_bit;
   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx, cnt_step;
   logic [N-1:0]  sh, sh_nx, sh_step;
   logic [N-1:0]  data, data_nx;
   logic          valid, valid_nx;
   logic          bit_err, bit_err_nx;
   logic          drop, drop_nx;
   logic          frame_end;

   // Identical sampling paths keep s_clk/s_sda/latch aligned; latch idles high.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clk_sync <= '0;
         sda_sync <= '0;
         lat_sync <= '1;
         clk_dly  <= 1'b0;
         lat_dly  <= 1'b1;
      end else begin
         clk_sync[0] <= bus.s_clk;
         sda_sync[0] <= bus.s_sda;
         lat_sync[0] <= bus.latch;
         for (int i = 1; i < int'(D); i++) begin
            clk_sync[i] <= clk_sync[i-1];
            sda_sync[i] <= sda_sync[i-1];
            lat_sync[i] <= lat_sync[i-1];
         end
         clk_dly <= clk_sync[D-1];
         lat_dly <= lat_sync[D-1];
      end
   end

   assign clk_rise = clk_sync[D-1] & ~clk_dly;
   assign lat_fall = ~lat_sync[D-1] & lat_dly;
   assign sda_bit  = sda_sync[D-1];

   // Shift and saturating count first, so a same-cycle latch sees the new bit.
   assign sh_step  = clk_rise ? {sh[N-2:0], sda_bit} : sh;
   assign cnt_step = (clk_rise && cnt != CW'(N + 1)) ? cnt + CW'(1) : cnt;
   assign frame_end = lat_fall && (state == SHIFT || clk_rise);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         sh      <= '0;
         data    <= '0;
         valid   <= 1'b0;
         bit_err <= 1'b0;
         drop    <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         sh      <= sh_nx;
         data    <= data_nx;
         valid   <= valid_nx;
         bit_err <= bit_err_nx;
         drop    <= drop_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt_step;
      sh_nx      = sh_step;
      data_nx    = data;
      valid_nx   = valid;
      bit_err_nx = 1'b0;
      drop_nx    = 1'b0;

      if (valid && bus.ready) valid_nx = 1'b0;

      case (state)
         IDLE:    if (clk_rise) state_nx = SHIFT;
         SHIFT:   ;
         default: state_nx = IDLE;
      endcase

      // Frame evaluation on latch; a full holding register without ready drops the word.
      if (frame_end) begin
         state_nx = IDLE;
         cnt_nx   = '0;
         sh_nx    = '0;
         if (cnt_step == CW'(N)) begin
            if (!valid || bus.ready) begin
               data_nx  = sh_step;
               valid_nx = 1'b1;
            end else begin
               drop_nx = 1'b1;
            end
         end else begin
            bit_err_nx = 1'b1;
         end
      end
   end

   assign bus.data    = data;
   assign bus.valid   = valid;
   assign bus.bit_err = bit_err;
   assign bus.drop    = drop;
endmodule

// File: tb/tb_receive_unit.sv
// Scoreboard bench for receive_unit: frame outcomes predicted from bit counts and values,
// checked by an independent monitor against the word and pulse outputs.
module tb_receive_unit;
   localparam int unsigned N = 8;
`ifdef RECEIVE_SYNC_EN
   localparam int D = 2;
`else
   localparam int D = 1;
`endif

   typedef enum logic [1:0] {EV_ERR, EV_DROP} ev_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   receive_unit_if #(.N(N)) bus ();
   receive_unit #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int errors = 0;
   int checks = 0;
   logic [N-1:0] word_q[$];
   ev_t          ev_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_unexpected(input string name, input logic [31:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got %0h with nothing expected", name, act);
   endtask

   // Monitor: each handshake, bit_err pulse and drop pulse consumes one prediction.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.valid && bus.ready) begin
            if (word_q.size() == 0) fail_unexpected("word", 32'(bus.data));
            else check("word", 32'(bus.data), 32'(word_q.pop_front()));
         end
         if (bus.bit_err) begin
            if (ev_q.size() == 0) fail_unexpected("bit_err", 32'd1);
            else check("bit_err_event", 32'(EV_ERR), 32'(ev_q.pop_front()));
         end
         if (bus.drop) begin
            if (ev_q.size() == 0) fail_unexpected("drop", 32'd1);
            else check("drop_event", 32'(EV_DROP), 32'(ev_q.pop_front()));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model: only the last N bits matter; anything but exactly N bits is an error.
   task automatic expect_frame(input logic [31:0] v, input int nb, input bit full);
      if (nb == int'(N)) begin
         if (full) ev_q.push_back(EV_DROP);
         else word_q.push_back(v[N-1:0]);
      end else if (nb > 0) begin
         ev_q.push_back(EV_ERR);
      end
   endtask

   task automatic send_bits(input logic [31:0] v, input int nb);
      for (int i = nb - 1; i >= 0; i--) begin
         bus.s_sda = v[i];
         bus.s_clk = 1'b0;
         cyc(3);
         bus.s_clk = 1'b1;
         cyc(3);
      end
   endtask

   task automatic latch_pulse();
      bus.latch = 1'b0;
      cyc(1);
      bus.latch = 1'b1;
      cyc(D + 4);
   endtask

   task automatic frame(input logic [31:0] v, input int nb, input bit full);
      expect_frame(v, nb, full);
      send_bits(v, nb);
      latch_pulse();
   endtask

   initial begin
      bus.s_clk = 1'b0;
      bus.s_sda = 1'b0;
      bus.latch = 1'b1;
      bus.ready = 1'b1;
      cyc(3);
      check("reset_valid", 32'(bus.valid), 32'd0);
      check("reset_data", 32'(bus.data), 32'd0);
      check("reset_bit_err", 32'(bus.bit_err), 32'd0);
      check("reset_drop", 32'(bus.drop), 32'd0);
      rst_n = 1'b1;
      cyc(2);

      // Good frame with latency: valid one edge after latch takes effect, then gone.
      expect_frame(32'hA5, 8, 1'b0);
      send_bits(32'hA5, 8);
      bus.latch = 1'b0;
      for (int k = 1; k <= D + 2; k++) begin
         cyc(1);
         if (k == 1) bus.latch = 1'b1;
         check("valid_latency", 32'(bus.valid), 32'(k == D + 1));
         if (k == D + 1) check("data_a5", 32'(bus.data), 32'hA5);
      end
      cyc(3);

      // Short and long frames.
      frame(32'h15, 5, 1'b0);
      check("short_no_valid", 32'(bus.valid), 32'd0);
      frame(32'h3C3, 10, 1'b0);
      check("long_no_valid", 32'(bus.valid), 32'd0);

      // Backpressure: second frame dropped, first word held.
      bus.ready = 1'b0;
      frame(32'h12, 8, 1'b0);
      check("bp_valid1", 32'(bus.valid), 32'd1);
      check("bp_data1", 32'(bus.data), 32'h12);
      frame(32'h34, 8, 1'b1);
      check("bp_valid2", 32'(bus.valid), 32'd1);
      check("bp_data2", 32'(bus.data), 32'h12);
      bus.ready = 1'b1;
      cyc(2);
      check("bp_released", 32'(bus.valid), 32'd0);

      // Collision: held word consumed on the same edge the new word loads.
      bus.ready = 1'b0;
      frame(32'h12, 8, 1'b0);
      expect_frame(32'h56, 8, 1'b0);
      send_bits(32'h56, 8);
      bus.latch = 1'b0;
      for (int k = 1; k <= D + 1; k++) begin
         cyc(1);
         if (k == 1) bus.latch = 1'b1;
         if (k == D) bus.ready = 1'b1;
         if (k == D + 1) begin
            bus.ready = 1'b0;
            check("coll_valid", 32'(bus.valid), 32'd1);
            check("coll_data", 32'(bus.data), 32'h56);
         end
      end
      cyc(2);
      bus.ready = 1'b1;
      cyc(3);

      // Reset mid-frame, then an empty latch, then a clean frame.
      send_bits(32'hF, 4);
      rst_n = 1'b0;
      bus.s_clk = 1'b0;
      cyc(2);
      check("rst_valid", 32'(bus.valid), 32'd0);
      check("rst_data", 32'(bus.data), 32'd0);
      check("rst_bit_err", 32'(bus.bit_err), 32'd0);
      check("rst_drop", 32'(bus.drop), 32'd0);
      rst_n = 1'b1;
      cyc(3);
      latch_pulse();
      frame(32'h5A, 8, 1'b0);

      // Randomized frames with ready held high.
      for (int f = 0; f < 20; f++) begin
         int nb;
         logic [31:0] v;
         nb = ($urandom_range(0, 1) == 1) ? int'(N) : int'($urandom_range(1, N + 3));
         v = $urandom;
         frame(v, nb, 1'b0);
      end

      cyc(10);
      check("words_drained", 32'(word_q.size()), 32'd0);
      check("events_drained", 32'(ev_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/receive_unit.md
# receive_unit

Serial-to-parallel capture block for the colour-shield serial link: it samples the `s_clk`/`s_sda`/`latch` lines driven by the shield transmit path and reassembles each latched frame into an N-bit word. It is the far end of the serial protocol. It sits on loopback/monitor paths so the design can self-check frames before they reach the DM163, and it provides the sink model for transmit-side verification. Captured words are presented on a valid/ready output with a one-word holding register.

## Interface
Parameters:
- `N`, 8, frame width in bits; ≥ 2.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `s_clk`  in  1  serial clock line; data sampled on its rising edge.
- `s_sda`  in  1  serial data line, MSB first.
- `latch`  in  1  frame latch, active-low.
- `data`  out  N  captured word; stable while `valid`=1.
- `valid`  out  1  `data` holds an unconsumed word.
- `ready`  in  1  consumer accepts word when `valid`&&`ready`.
- `bit_err`  out  1  one-cycle pulse: frame latched with 1..N-1 or >N bits.
- `drop`  out  1  one-cycle pulse: good frame discarded because holding register full.

## Operation
- Input stage: `s_clk`, `s_sda`, `latch` each pass through D register stages (D set by Configuration). Edge detection compares the last stage with a one-cycle-delayed copy. All three lines use identical paths, so their relative alignment is preserved.
- `clk_rise` = sampled `s_clk` 0→1. `lat_fall` = sampled `latch` 1→0. Levels held at 0 or low produce no further events.
- Shift register `sh[N-1:0]`: on `clk_rise`, `sh <= {sh[N-2:0], sda_sampled}`. Bits beyond N shift out of the MSB.
- Bit counter `cnt`, width `$clog2(N+2)`: +1 on `clk_rise`, saturating at N+1 (overlength marker).
- FSM:
  - IDLE (`cnt`=0): `clk_rise` moves to SHIFT.
  - SHIFT (1 ≤ `cnt` ≤ N+1): counts bits. On `lat_fall`, goes to IDLE.
  - On that `lat_fall`, the FSM clears `cnt` and `sh`.
  - `lat_fall` in IDLE (empty frame) is ignored: no pulse, no word.
- Frame evaluation at `lat_fall`, using the count after any same-cycle `clk_rise`:
  - `cnt`==N: good frame.
  - Any other nonzero `cnt`: `bit_err`=1 for one cycle; word discarded.
- Good-frame delivery:
  - If the holding register is empty, or `valid`&&`ready` in the same cycle: `data <= sh` (including any same-cycle bit) and `valid <= 1`.
  - Otherwise the held word is kept unchanged and `drop`=1 for one cycle.
- `valid` clears on the edge after `valid`&&`ready` unless a new word loads on that edge.
- Simultaneous `clk_rise` and `lat_fall`: the shift is applied first, then the frame is evaluated.
- Reset (`rst_n`=0 at a clk edge), also mid-frame:
  - `cnt`=0, `sh`=0, FSM=IDLE.
  - `data`=0, `valid`=0, `bit_err`=0, `drop`=0.
  - All sampled/delayed `s_clk`, `s_sda` stages = 0; all `latch` stages = 1, so no spurious edge is detected after release.

## Timing
- Event latency: a line change first sampled at clk edge e0 takes effect, and the outputs update, at edge e0+D-1+1. That is 2 edges with the synchronizer and 1 edge without.
- Minimum `s_clk` high and low time: 2 `clk` cycles each. Minimum `latch` low: 1 cycle.
- `s_sda` must be stable from ≥1 cycle before to ≥1 cycle after each `s_clk` rise. The shield transmitter satisfies this with 3-cycle half periods.
- `bit_err` and `drop` are registered, one cycle wide, and asserted on the same edge that `valid` would have updated.
- Back-to-back frames: a new frame may start the cycle after `latch` returns high. With `ready` held at 1 there is no throughput loss.

## Configuration
- `RECEIVE_SYNC_EN` defined: D=2. This gives a two-flop synchronizer per input, for lines from another clock domain or from off-chip.
- `RECEIVE_SYNC_EN` undefined: D=1. This gives a single sampling register per input, for same-clock loopback only.
- Function is otherwise identical. Only the latency changes, as given in Timing.

## Test plan
- Good frame: N=8, `RECEIVE_SYNC_EN` on, transmit 0xA5 (3-cycle half periods), `latch` low 1 cycle, `ready`=1.
  - `valid` rises 2 edges after latch low is first sampled, with `data`=0xA5.
  - `valid` falls on the next edge.
- Short frame: 5 bits then latch → `bit_err` pulses exactly 1 cycle; `valid` stays 0.
- Long frame: 10 bits (1,1, then 0xC3) then latch → `bit_err` pulse; no word delivered.
- Backpressure, `ready`=0, frames 0x12 then 0x34:
  - `valid`=1 with `data`=0x12 throughout.
  - `drop` pulses at the second latch.
  - Raising `ready` consumes 0x12 and `valid` falls.
- Handshake collision: latch of 0x56 on the same cycle as `valid`&&`ready` for a held 0x12 → `data`=0x56, `valid` stays 1, no `drop`.
- Reset and empty frame:
  - Assert `rst_n`=0 after 4 bits → all outputs 0.
  - A `latch` pulse with no bits produces nothing.
  - A following frame 0x5A is captured as exactly 0x5A.
